// File: rtl/count_display_if.sv
// Counter-to-display bus: binary count in, converted BCD, status and 7-segment scan out.
interface count_display_if #(
  parameter int N      = 6,
  parameter int DIGITS = 2
);
  logic [N-1:0]        q;
  logic [4*DIGITS-1:0] bcd;
  logic                valid;
  logic                busy;
  logic                ovf;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;

  modport master (output q, input bcd, valid, busy, ovf, seg, an);
  modport slave  (input q, output bcd, valid, busy, ovf, seg, an);
endinterface

// File: rtl/count_display.sv
// Binary-to-BCD double-dabble converter with a multiplexed 7-segment scanner.
// Define COUNT_DISPLAY_BLANK_EN to suppress leading zeros on the display.
module count_display #(
  parameter int N           = 6,
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  count_display_if.slave bus
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(N+1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10m1(input int d);
    longint unsigned p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction
  localparam longint unsigned MAXV = pow10m1(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   sh, lat;
  logic [BW-1:0]  scr, adj, bcd_r;
  logic [CW-1:0]  bcnt;
  logic           valid_r, busy_r, ovf_r;
  logic           ovf_c;

  assign ovf_c = (64'(lat) > MAXV);

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_add3
      assign adj[4*k +: 4] = (scr[4*k +: 4] >= 4'd5) ? scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      lat     <= '0;
      scr     <= '0;
      bcnt    <= '0;
      bcd_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sh     <= bus.q;
          lat    <= bus.q;
          scr    <= '0;
          bcnt   <= CW'(N);
          busy_r <= 1'b1;
          state  <= SHIFT;
        end
        SHIFT: begin
          {scr, sh} <= {adj[BW-2:0], sh, 1'b0};
          bcnt      <= bcnt - 1'b1;
          if (bcnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          // Saturate to all nines rather than show a truncated wrong value
          ovf_r   <= ovf_c;
          bcd_r   <= ovf_c ? {DIGITS{4'h9}} : scr;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [RW-1:0] rcnt;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV-1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(DIGITS-1)) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  logic [3:0] dig [DIGITS];
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      assign dig[k] = bcd_r[4*k +: 4];
    end
  endgenerate

`ifdef COUNT_DISPLAY_BLANK_EN
  // hz[k]: digit k and every digit above it are zero
  logic [DIGITS:0] hz;
  assign hz[DIGITS] = 1'b1;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_hz
      assign hz[k] = (dig[k] == 4'd0) && hz[k+1];
    end
  endgenerate
`endif

  logic [6:0]        seg_c;
  logic [DIGITS-1:0] an_c;

  always_comb begin
    seg_c = 7'h7F;
    an_c  = '1;
    if (valid_r) begin
      an_c[idx] = 1'b0;
      case (dig[idx])
        4'd0:    seg_c = 7'h40;
        4'd1:    seg_c = 7'h79;
        4'd2:    seg_c = 7'h24;
        4'd3:    seg_c = 7'h30;
        4'd4:    seg_c = 7'h19;
        4'd5:    seg_c = 7'h12;
        4'd6:    seg_c = 7'h02;
        4'd7:    seg_c = 7'h78;
        4'd8:    seg_c = 7'h00;
        4'd9:    seg_c = 7'h10;
        default: seg_c = 7'h7F;
      endcase
`ifdef COUNT_DISPLAY_BLANK_EN
      if (idx != '0 && hz[idx]) seg_c = 7'h7F;
`endif
    end
  end

  assign bus.bcd   = bcd_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.ovf   = ovf_r;
  assign bus.seg   = seg_c;
  assign bus.an    = an_c;
endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display: default N=6 instance plus an N=8 instance for overflow.
module tb_count_display;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   k = 0;

  always #5 clk = ~clk;

  count_display_if #(.N(6), .DIGITS(2)) b6 ();
  count_display_if #(.N(8), .DIGITS(2)) b8 ();

  count_display #(.N(6), .DIGITS(2), .REFRESH_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .bus(b6)
  );
  count_display #(.N(8), .DIGITS(2), .REFRESH_DIV(4)) u_dut8 (
    .clk(clk), .reset(reset), .bus(b8)
  );

`ifdef COUNT_DISPLAY_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'h7F;
`else
  localparam logic [6:0] HI_ZERO = 7'h40;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    k++;
  endtask

  initial begin
    reset = 1'b1;
    b6.q  = 6'd37;
    b8.q  = 8'd200;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an",    32'(b6.an),    32'h3);
      chk("rst_seg",   32'(b6.seg),   32'h7F);
      chk("rst_bcd",   32'(b6.bcd),   32'h0);
      chk("rst_valid", 32'(b6.valid), 32'h0);
      chk("rst_busy",  32'(b6.busy),  32'h0);
    end

    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (k == 7) begin
        chk("lat_valid_early", 32'(b6.valid), 32'h0);
        chk("lat_bcd_early",   32'(b6.bcd),   32'h0);
      end
      if (k == 8) begin
        chk("bcd37",     32'(b6.bcd),   32'h37);
        chk("valid37",   32'(b6.valid), 32'h1);
        chk("busy_idle", 32'(b6.busy),  32'h0);
      end
      if (k == 9) chk("busy_shift", 32'(b6.busy), 32'h1);
      if (k >= 8 && k <= 16) begin
        if (((k / 4) % 2) == 0) begin
          chk("scan_an0",  32'(b6.an),  32'h2);
          chk("scan_seg0", 32'(b6.seg), 32'h78);
        end else begin
          chk("scan_an1",  32'(b6.an),  32'h1);
          chk("scan_seg1", 32'(b6.seg), 32'h30);
        end
      end
      if (k == 10) begin
        chk("ovf8_hi", 32'(b8.ovf), 32'h1);
        chk("bcd8_hi", 32'(b8.bcd), 32'h99);
        b8.q = 8'd63;
      end
      if (k == 19) chk("bcd8_hold", 32'(b8.bcd), 32'h99);
      if (k == 20) begin
        chk("ovf8_lo", 32'(b8.ovf), 32'h0);
        chk("bcd8_lo", 32'(b8.bcd), 32'h63);
      end
      // the IDLE sample at edge 17 already took 37; this change lands in SHIFT
      if (k == 17) b6.q = 6'd42;
      if (k == 24) chk("ignore_mid", 32'(b6.bcd), 32'h37);
      if (k == 31) chk("hold37",     32'(b6.bcd), 32'h37);
      if (k == 32) chk("bcd42",      32'(b6.bcd), 32'h42);
    end

    // third SHIFT cycle of the conversion sampled at edge 33
    while (k < 35) tick();
    reset = 1'b1;
    #1;
    chk("abort_bcd",   32'(b6.bcd),   32'h0);
    chk("abort_valid", 32'(b6.valid), 32'h0);
    chk("abort_an",    32'(b6.an),    32'h3);
    chk("abort_seg",   32'(b6.seg),   32'h7F);
    tick();
    reset = 1'b0;
    k = 0;
    for (int c = 0; c < 28; c++) begin
      tick();
      if (k == 7) chk("rel_valid_early", 32'(b6.valid), 32'h0);
      if (k == 8) begin
        chk("rel_bcd",   32'(b6.bcd),   32'h42);
        chk("rel_valid", 32'(b6.valid), 32'h1);
        b6.q = 6'd5;
      end
      if (k == 16) begin
        chk("bcd05",    32'(b6.bcd), 32'h05);
        chk("d0_seg5",  32'(b6.seg), 32'h12);
        chk("d0_an5",   32'(b6.an),  32'h2);
        b6.q = 6'd0;
      end
      if (k == 20) begin
        chk("d1_an5",  32'(b6.an),  32'h1);
        chk("d1_seg5", 32'(b6.seg), 32'(HI_ZERO));
      end
      if (k == 24) begin
        chk("bcd00",   32'(b6.bcd), 32'h00);
        chk("d0_seg0", 32'(b6.seg), 32'h40);
      end
      if (k == 28) chk("d1_seg0", 32'(b6.seg), 32'(HI_ZERO));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
